dma_tile_scheduler: RTL and testbench

- Sequences the DMA channels around the systolic array for a multi-tile job.
- Issues one weight (K) read command, then per-tile input (X) read and output (Y) write commands with strided addresses.
- Reports busy/done/irq back to the AXI-Lite register file.
- Sits between the AXI-Lite config registers and the three DMA command ports inside the AXI integration top.

---
 rtl/dma_sched_pkg.sv | 18 +
 rtl/dma_cmd_slot.sv | 46 ++++
 rtl/dma_tile_scheduler.sv | 173 +++++++++++++++++
 tb/tb_dma_tile_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_sched_pkg.sv
// Shared types for the DMA tile scheduler: FSM state encoding, command
// record and default field widths.
package dma_sched_pkg;

  localparam int WA_DEF = 32;
  localparam int WL_DEF = 24;
  localparam int WT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE, CMD_K, WAIT_K, CMD_XY, WAIT_XY, FIN
  } state_t;

  typedef struct packed {
    logic [WA_DEF-1:0] addr;
    logic [WL_DEF-1:0] bytes;
  } cmd_t;

endpackage

// File: rtl/dma_cmd_slot.sv
// One DMA command channel: holds valid/addr/bytes from issue until the
// handshake, plus a sticky completion flag. A zero-length load issues no
// command and pre-sets the flag so the channel never blocks the tile.
module dma_cmd_slot
  import dma_sched_pkg::*;
#(
  parameter int WA = WA_DEF,
  parameter int WL = WL_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [WA-1:0] load_addr,
  input  logic [WL-1:0] load_bytes,
  input  logic          ready,
  input  logic          capture,
  input  logic          done_in,
  output logic          valid,
  output logic [WA-1:0] addr,
  output logic [WL-1:0] bytes,
  output logic          flag
);

  // Command register: load on issue, drop valid only on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      bytes <= '0;
    end else if (load) begin
      valid <= (load_bytes != '0);
      addr  <= load_addr;
      bytes <= load_bytes;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  // Sticky done flag: cleared on issue, set by any done while capturing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   flag <= 1'b0;
    else if (load)             flag <= (load_bytes == '0);
    else if (capture && done_in) flag <= 1'b1;
  end

endmodule

// File: rtl/dma_tile_scheduler.sv
// DMA tile scheduler: one K read, then per-tile X read / Y write commands
// with strided addresses, reporting busy/done/irq.
// Optional: define SCHED_PERF_CNT_EN to build the busy-cycle counter on
// perf_cycles; otherwise perf_cycles is tied to 0.
module dma_tile_scheduler
  import dma_sched_pkg::*;
#(
  parameter int WA = WA_DEF,
  parameter int WL = WL_DEF,
  parameter int WT = WT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WA-1:0] cfg_k_addr,
  input  logic [WA-1:0] cfg_x_addr,
  input  logic [WA-1:0] cfg_y_addr,
  input  logic [WL-1:0] cfg_k_bytes,
  input  logic [WL-1:0] cfg_x_bytes,
  input  logic [WL-1:0] cfg_y_bytes,
  input  logic [WA-1:0] cfg_x_stride,
  input  logic [WA-1:0] cfg_y_stride,
  input  logic [WT-1:0] cfg_n_tiles,
  output logic          k_cmd_valid,
  input  logic          k_cmd_ready,
  output logic [WA-1:0] k_cmd_addr,
  output logic [WL-1:0] k_cmd_bytes,
  output logic          x_cmd_valid,
  input  logic          x_cmd_ready,
  output logic [WA-1:0] x_cmd_addr,
  output logic [WL-1:0] x_cmd_bytes,
  output logic          y_cmd_valid,
  input  logic          y_cmd_ready,
  output logic [WA-1:0] y_cmd_addr,
  output logic [WL-1:0] y_cmd_bytes,
  input  logic          k_done,
  input  logic          x_done,
  input  logic          y_done,
  output logic          busy,
  output logic          done,
  output logic          irq,
  input  logic          irq_clr,
  output logic [WT-1:0] tile_idx,
  output logic [31:0]   perf_cycles
);

  state_t        state, nstate;
  logic [WL-1:0] x_bytes_q, y_bytes_q;
  logic [WA-1:0] x_stride_q, y_stride_q;
  logic [WT-1:0] n_tiles_q;
  logic [WA-1:0] x_acc, y_acc, x_acc_d, y_acc_d;
  logic [WL-1:0] x_bytes_eff, y_bytes_eff;
  logic [WT-1:0] tile_next;
  logic          accept, tile_adv, k_load, xy_load;
  logic          k_flag, x_flag, y_flag;

  assign accept    = (state == IDLE) && start;
  assign tile_adv  = (state == WAIT_XY) && x_flag && y_flag;
  assign tile_next = tile_idx + WT'(1);
  assign k_load    = accept && (cfg_k_bytes != '0);
  assign xy_load   = (nstate == CMD_XY) && (state != CMD_XY);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  // Config is not latched yet when jumping straight from IDLE to CMD_XY.
  assign x_bytes_eff = (state == IDLE) ? cfg_x_bytes : x_bytes_q;
  assign y_bytes_eff = (state == IDLE) ? cfg_y_bytes : y_bytes_q;

  // Running address accumulators; value presented to the slots on load.
  assign x_acc_d = accept ? cfg_x_addr : (tile_adv ? x_acc + x_stride_q : x_acc);
  assign y_acc_d = accept ? cfg_y_addr : (tile_adv ? y_acc + y_stride_q : y_acc);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:
        if (start) begin
          if (cfg_k_bytes != '0)      nstate = CMD_K;
          else if (cfg_n_tiles != '0) nstate = CMD_XY;
          else                        nstate = FIN;
        end
      CMD_K:
        if (k_cmd_valid && k_cmd_ready) nstate = WAIT_K;
      WAIT_K:
        if (k_flag) nstate = (n_tiles_q == '0) ? FIN : CMD_XY;
      CMD_XY:
        if ((!x_cmd_valid || x_cmd_ready) && (!y_cmd_valid || y_cmd_ready))
          nstate = WAIT_XY;
      WAIT_XY:
        if (tile_adv) nstate = (tile_next == n_tiles_q) ? FIN : CMD_XY;
      FIN:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Job context: config latch, address accumulators, tile index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_bytes_q  <= '0;
      y_bytes_q  <= '0;
      x_stride_q <= '0;
      y_stride_q <= '0;
      n_tiles_q  <= '0;
      x_acc      <= '0;
      y_acc      <= '0;
      tile_idx   <= '0;
    end else begin
      if (accept) begin
        x_bytes_q  <= cfg_x_bytes;
        y_bytes_q  <= cfg_y_bytes;
        x_stride_q <= cfg_x_stride;
        y_stride_q <= cfg_y_stride;
        n_tiles_q  <= cfg_n_tiles;
        tile_idx   <= '0;
      end else if (tile_adv) begin
        tile_idx <= tile_next;
      end
      x_acc <= x_acc_d;
      y_acc <= y_acc_d;
    end
  end

  // Sticky interrupt; a set on FIN entry beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 irq <= 1'b0;
    else if (nstate == FIN)  irq <= 1'b1;
    else if (irq_clr)        irq <= 1'b0;
  end

  dma_cmd_slot #(.WA(WA), .WL(WL)) u_k_slot (
    .clk(clk), .rst(rst), .load(k_load), .load_addr(cfg_k_addr),
    .load_bytes(cfg_k_bytes), .ready(k_cmd_ready),
    .capture((state == CMD_K) || (state == WAIT_K)), .done_in(k_done),
    .valid(k_cmd_valid), .addr(k_cmd_addr), .bytes(k_cmd_bytes), .flag(k_flag)
  );

  dma_cmd_slot #(.WA(WA), .WL(WL)) u_x_slot (
    .clk(clk), .rst(rst), .load(xy_load), .load_addr(x_acc_d),
    .load_bytes(x_bytes_eff), .ready(x_cmd_ready),
    .capture((state == CMD_XY) || (state == WAIT_XY)), .done_in(x_done),
    .valid(x_cmd_valid), .addr(x_cmd_addr), .bytes(x_cmd_bytes), .flag(x_flag)
  );

  dma_cmd_slot #(.WA(WA), .WL(WL)) u_y_slot (
    .clk(clk), .rst(rst), .load(xy_load), .load_addr(y_acc_d),
    .load_bytes(y_bytes_eff), .ready(y_cmd_ready),
    .capture((state == CMD_XY) || (state == WAIT_XY)), .done_in(y_done),
    .valid(y_cmd_valid), .addr(y_cmd_addr), .bytes(y_cmd_bytes), .flag(y_flag)
  );

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_q;

  // Busy-cycle counter: restart per job, saturate, hold after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          perf_q <= '0;
    else if (accept)                  perf_q <= '0;
    else if (busy && (perf_q != '1))  perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_dma_tile_scheduler.sv
// Self-checking bench for dma_tile_scheduler: directed and randomized jobs
// against an expected-command model, with a DMA responder applying random
// ready backpressure and completion pulses.
module tb_dma_tile_scheduler;
  import dma_sched_pkg::*;

  logic        clk, rst, start, irq_clr;
  logic [31:0] cfg_k_addr, cfg_x_addr, cfg_y_addr, cfg_x_stride, cfg_y_stride;
  logic [23:0] cfg_k_bytes, cfg_x_bytes, cfg_y_bytes;
  logic [15:0] cfg_n_tiles, tile_idx;
  logic        k_cmd_valid, x_cmd_valid, y_cmd_valid;
  logic        k_cmd_ready, x_cmd_ready, y_cmd_ready;
  logic [31:0] k_cmd_addr, x_cmd_addr, y_cmd_addr, perf_cycles;
  logic [23:0] k_cmd_bytes, x_cmd_bytes, y_cmd_bytes;
  logic        k_done, x_done, y_done, busy, done, irq;

  logic [2:0]  rdy, dn;
  logic        stray_k_done;
  assign k_cmd_ready = rdy[0];
  assign x_cmd_ready = rdy[1];
  assign y_cmd_ready = rdy[2];
  assign k_done = dn[0] | stray_k_done;
  assign x_done = dn[1];
  assign y_done = dn[2];

  dma_tile_scheduler dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_k_addr(cfg_k_addr), .cfg_x_addr(cfg_x_addr), .cfg_y_addr(cfg_y_addr),
    .cfg_k_bytes(cfg_k_bytes), .cfg_x_bytes(cfg_x_bytes), .cfg_y_bytes(cfg_y_bytes),
    .cfg_x_stride(cfg_x_stride), .cfg_y_stride(cfg_y_stride), .cfg_n_tiles(cfg_n_tiles),
    .k_cmd_valid(k_cmd_valid), .k_cmd_ready(k_cmd_ready), .k_cmd_addr(k_cmd_addr), .k_cmd_bytes(k_cmd_bytes),
    .x_cmd_valid(x_cmd_valid), .x_cmd_ready(x_cmd_ready), .x_cmd_addr(x_cmd_addr), .x_cmd_bytes(x_cmd_bytes),
    .y_cmd_valid(y_cmd_valid), .y_cmd_ready(y_cmd_ready), .y_cmd_addr(y_cmd_addr), .y_cmd_bytes(y_cmd_bytes),
    .k_done(k_done), .x_done(x_done), .y_done(y_done),
    .busy(busy), .done(done), .irq(irq), .irq_clr(irq_clr),
    .tile_idx(tile_idx), .perf_cycles(perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // DMA responder state
  int   ready_pct = 100;
  bit   same_done = 1'b0;
  bit   hold_done = 1'b0;
  int   cnt [3];
  bit   stall [3];
  cmd_t prev [3];
  cmd_t cur [3];
  logic [2:0] vld;
  cmd_t obs_k[$], obs_x[$], obs_y[$];
  int   done_cnt = 0;
  int   busy_cnt = 0;

  always_comb begin
    cur[0] = '{addr: k_cmd_addr, bytes: k_cmd_bytes};
    cur[1] = '{addr: x_cmd_addr, bytes: x_cmd_bytes};
    cur[2] = '{addr: y_cmd_addr, bytes: y_cmd_bytes};
    vld    = {y_cmd_valid, x_cmd_valid, k_cmd_valid};
  end

  // Responder: hold checks, done pulses, random ready, handshake capture.
  always @(negedge clk) begin
    if (rst) begin
      rdy = '0;
      dn  = '0;
      for (int c = 0; c < 3; c++) begin cnt[c] = -1; stall[c] = 1'b0; end
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (stall[c]) begin
          chk($sformatf("hold_valid_ch%0d", c), 64'(vld[c]), 64'(1));
          chk($sformatf("hold_cmd_ch%0d", c), 64'(cur[c]), 64'(prev[c]));
        end
        dn[c] = 1'b0;
        if (cnt[c] > 0) cnt[c]--;
        if (cnt[c] == 0) begin dn[c] = 1'b1; cnt[c] = -1; end
        rdy[c] = ($urandom_range(0, 99) < ready_pct);
        if (vld[c] && rdy[c]) begin
          case (c)
            0:       obs_k.push_back(cur[c]);
            1:       obs_x.push_back(cur[c]);
            default: obs_y.push_back(cur[c]);
          endcase
          if (!hold_done) begin
            if (same_done) dn[c] = 1'b1;
            else           cnt[c] = int'($urandom_range(1, 4));
          end
        end
        stall[c] = vld[c] && !rdy[c];
        prev[c]  = cur[c];
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic cmp_list(input string tag, input cmd_t o[$], input cmd_t e[$]);
    chk({tag, "_count"}, 64'(o.size()), 64'(e.size()));
    for (int i = 0; i < o.size() && i < e.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 64'(o[i]), 64'(e[i]));
  endtask

  task automatic run_job(input string nm,
                         input logic [31:0] ka, xa, ya, xs, ys,
                         input logic [23:0] kb, xb, yb,
                         input logic [15:0] n,
                         input bit busy_start, input bit clr_hold);
    cmd_t ek[$], ex[$], ey[$];
    int   lat;
    // Expected command stream straight from the job description.
    if (kb != 0) ek.push_back('{addr: ka, bytes: kb});
    for (int t = 0; t < int'(n); t++) begin
      if (xb != 0) ex.push_back('{addr: 32'(xa + xs * 32'(t)), bytes: xb});
      if (yb != 0) ey.push_back('{addr: 32'(ya + ys * 32'(t)), bytes: yb});
    end
    cfg_k_addr = ka; cfg_x_addr = xa; cfg_y_addr = ya;
    cfg_x_stride = xs; cfg_y_stride = ys;
    cfg_k_bytes = kb; cfg_x_bytes = xb; cfg_y_bytes = yb; cfg_n_tiles = n;
    obs_k.delete(); obs_x.delete(); obs_y.delete();
    done_cnt = 0; busy_cnt = 0;
    irq_clr = clr_hold;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 3000) begin
      if (busy_start && lat == 4) begin
        start = 1'b1; cfg_x_addr = 32'hDEAD_0000; cfg_n_tiles = 16'd7;
      end else start = 1'b0;
      step();
      lat++;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, 64'(done), 64'(1));
    chk({nm, "_irq_with_done"}, 64'(irq), 64'(1));
    chk({nm, "_tile_idx_fin"}, 64'(tile_idx), 64'(n));
    if (kb == 0 && n == 0) chk({nm, "_k0n0_latency_ok"}, 64'(lat <= 2), 64'(1));
    irq_clr = 1'b0;
    step();
    step();
    chk({nm, "_busy_after"}, 64'(busy), 64'(0));
    chk({nm, "_done_pulses"}, 64'(done_cnt), 64'(1));
    chk({nm, "_irq_sticky"}, 64'(irq), 64'(1));
    chk({nm, "_tile_idx_hold"}, 64'(tile_idx), 64'(n));
    cmp_list({nm, "_k"}, obs_k, ek);
    cmp_list({nm, "_x"}, obs_x, ex);
    cmp_list({nm, "_y"}, obs_y, ey);
`ifdef SCHED_PERF_CNT_EN
    chk({nm, "_perf"}, 64'(perf_cycles), 64'(busy_cnt));
`else
    chk({nm, "_perf"}, 64'(perf_cycles), 64'(0));
`endif
  endtask

  function automatic logic [23:0] rnd_bytes();
    return ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 4096));
  endfunction

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; irq_clr = 1'b0; stray_k_done = 1'b0;
    cfg_k_addr = '0; cfg_x_addr = '0; cfg_y_addr = '0;
    cfg_x_stride = '0; cfg_y_stride = '0;
    cfg_k_bytes = '0; cfg_x_bytes = '0; cfg_y_bytes = '0; cfg_n_tiles = '0;
    step(); step();
    chk("reset_outputs",
        64'({busy, done, irq, tile_idx, k_cmd_valid, x_cmd_valid, y_cmd_valid,
             perf_cycles != 0, k_cmd_addr != 0, x_cmd_addr != 0, y_cmd_addr != 0}), 64'(0));
    rst = 1'b0;
    step();
    chk("post_reset_idle", 64'({busy, done, irq, k_cmd_valid}), 64'(0));

    // Reference job, no backpressure, then with backpressure.
    run_job("basic", 32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h40,
            24'd64, 24'd32, 24'd16, 16'd3, 1'b0, 1'b0);
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    chk("irq_cleared", 64'(irq), 64'(0));
    ready_pct = 30;
    run_job("backpressure", 32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h40,
            24'd64, 24'd32, 24'd16, 16'd3, 1'b0, 1'b0);

    // Done pulses coincident with handshakes.
    same_done = 1'b1;
    run_job("same_cycle_done", 32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h40,
            24'd64, 24'd32, 24'd16, 16'd4, 1'b0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 4; j++) begin
      same_done = $urandom_range(0, 1) == 1;
      run_job($sformatf("rand%0d", j), $urandom, $urandom, $urandom, $urandom, $urandom,
              rnd_bytes(), rnd_bytes(), rnd_bytes(), 16'($urandom_range(1, 5)), 1'b0, 1'b0);
    end
    same_done = 1'b0;
    ready_pct = 100;

    // Boundary jobs.
    run_job("n0_k64", 32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h40,
            24'd64, 24'd32, 24'd16, 16'd0, 1'b0, 1'b0);
    run_job("k0_n0", 32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h40,
            24'd0, 24'd32, 24'd16, 16'd0, 1'b0, 1'b0);
    run_job("x_wrap", 32'h1000, 32'hFFFF_FF00, 32'h3000, 32'h100, 32'h40,
            24'd0, 24'd32, 24'd16, 16'd2, 1'b0, 1'b0);
    ready_pct = 50;
    run_job("start_busy_clr", 32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h40,
            24'd64, 24'd32, 24'd16, 16'd3, 1'b1, 1'b1);
    ready_pct = 100;

    // Stray k_done while idle.
    stray_k_done = 1'b1; step(); stray_k_done = 1'b0; step();
    chk("stray_kdone_ignored", 64'({busy, done, k_cmd_valid}), 64'(0));

    // Reset while waiting for tile completion.
    hold_done = 1'b1;
    cfg_n_tiles = 16'd4; cfg_k_bytes = 24'd0; cfg_x_bytes = 24'd32; cfg_y_bytes = 24'd16;
    obs_x.delete(); obs_y.delete();
    start = 1'b1; step(); start = 1'b0;
    w = 0;
    while (!(obs_x.size() > 0 && obs_y.size() > 0) && w < 200) begin step(); w++; end
    chk("rst_job_reached_wait", 64'(w < 200), 64'(1));
    step(); step();
    done_cnt = 0;
    rst = 1'b1;
    #1;
    chk("rst_midjob_outputs",
        64'({busy, done, irq, tile_idx, k_cmd_valid, x_cmd_valid, y_cmd_valid,
             perf_cycles != 0, x_cmd_addr != 0}), 64'(0));
    step();
    rst = 1'b0; hold_done = 1'b0;
    step(); step();
    chk("rst_midjob_no_done", 64'({done_cnt != 0, irq, busy}), 64'(0));
    run_job("after_reset", 32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h40,
            24'd64, 24'd32, 24'd16, 16'd3, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
